// File: rtl/pe_dot_accum_4xpack_if.sv
// rtl/pe_dot_accum_4xpack_if.sv - product-beat input and dot-result output bundle for pe_dot_accum_4xpack
interface pe_dot_accum_4xpack_if #(
    parameter int DOT_SIZE          = 8,
    parameter int MULT_OUTPUT_WIDTH = 9,
    parameter int ACCUM_WIDTH       = 24
);
    logic                                                    i_valid;
    logic                                                    i_first;
    logic                                                    i_last;
    // sign-magnitude products indexed [feature][filter][dot]
    logic [1:0][1:0][DOT_SIZE-1:0][MULT_OUTPUT_WIDTH-1:0]    i_mult;
    logic                                                    o_valid;
    logic [1:0][1:0][ACCUM_WIDTH-1:0]                        o_result;
    logic [1:0][1:0]                                         o_overflow;

    modport master (
        output i_valid, i_first, i_last, i_mult,
        input  o_valid, o_result, o_overflow
    );

    modport slave (
        input  i_valid, i_first, i_last, i_mult,
        output o_valid, o_result, o_overflow
    );
endinterface

// File: rtl/pe_dot_accum_4xpack.sv
// rtl/pe_dot_accum_4xpack.sv - per-lane sign-magnitude dot reduction with saturating window accumulator
module pe_dot_accum_4xpack #(
    parameter int DOT_SIZE            = 8,
    parameter int MULT_OUTPUT_WIDTH   = 9,
    parameter int ACCUM_WIDTH         = 24,
    parameter int NUM_PACKED_FEATURES = 2,
    parameter int NUM_PACKED_FILTERS  = 2
) (
    input logic                     clock,
    input logic                     reset,
    pe_dot_accum_4xpack_if.slave    bus
);
    localparam int MW    = MULT_OUTPUT_WIDTH;
    localparam int SUM_W = MW + $clog2(DOT_SIZE);
    // one guard bit above whichever of acc / beat sum is wider, so the
    // pre-clamp value is exact even when the accumulator is the narrower one
    localparam int EXT_W = ((ACCUM_WIDTH > SUM_W) ? ACCUM_WIDTH : SUM_W) + 1;

    localparam logic signed [EXT_W-1:0] ACC_MAX =
        {{(EXT_W-ACCUM_WIDTH+1){1'b0}}, {(ACCUM_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN =
        {{(EXT_W-ACCUM_WIDTH+1){1'b1}}, {(ACCUM_WIDTH-1){1'b0}}};

    // S1 state
    logic                         s1_valid, s1_first, s1_last;
    logic signed [MW-1:0]         s1_term [NUM_PACKED_FEATURES][NUM_PACKED_FILTERS][DOT_SIZE];
    // S2 state
    logic                         s2_valid, s2_first, s2_last;
    logic signed [SUM_W-1:0]      s2_sum  [NUM_PACKED_FEATURES][NUM_PACKED_FILTERS];
    // S3 state
    logic signed [ACCUM_WIDTH-1:0] acc    [NUM_PACKED_FEATURES][NUM_PACKED_FILTERS];
    logic                          sticky [NUM_PACKED_FEATURES][NUM_PACKED_FILTERS];

    logic signed [SUM_W-1:0]       tree_sum [NUM_PACKED_FEATURES][NUM_PACKED_FILTERS];
    logic signed [EXT_W-1:0]       acc_wide [NUM_PACKED_FEATURES][NUM_PACKED_FILTERS];
    logic signed [ACCUM_WIDTH-1:0] acc_next [NUM_PACKED_FEATURES][NUM_PACKED_FILTERS];
    logic                          ovf_next [NUM_PACKED_FEATURES][NUM_PACKED_FILTERS];

    // S1: sign-magnitude to two's complement; negative zero falls out as 0
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            for (int f = 0; f < NUM_PACKED_FEATURES; f++)
                for (int k = 0; k < NUM_PACKED_FILTERS; k++)
                    for (int d = 0; d < DOT_SIZE; d++)
                        s1_term[f][k][d] <= '0;
        end else begin
            s1_valid <= bus.i_valid;
            s1_first <= bus.i_valid & bus.i_first;
            s1_last  <= bus.i_valid & bus.i_last;
            for (int f = 0; f < NUM_PACKED_FEATURES; f++)
                for (int k = 0; k < NUM_PACKED_FILTERS; k++)
                    for (int d = 0; d < DOT_SIZE; d++) begin
                        if (bus.i_mult[f][k][d][MW-1])
                            s1_term[f][k][d] <= -$signed({1'b0, bus.i_mult[f][k][d][MW-2:0]});
                        else
                            s1_term[f][k][d] <= $signed({1'b0, bus.i_mult[f][k][d][MW-2:0]});
                    end
        end
    end

    // full-precision reduction of the DOT_SIZE terms of each lane
    always_comb begin
        for (int f = 0; f < NUM_PACKED_FEATURES; f++)
            for (int k = 0; k < NUM_PACKED_FILTERS; k++) begin
                tree_sum[f][k] = '0;
                for (int d = 0; d < DOT_SIZE; d++)
                    tree_sum[f][k] = tree_sum[f][k] + SUM_W'(s1_term[f][k][d]);
            end
    end

    // S2: register the lane sums and carry the beat flags along
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            for (int f = 0; f < NUM_PACKED_FEATURES; f++)
                for (int k = 0; k < NUM_PACKED_FILTERS; k++)
                    s2_sum[f][k] <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            for (int f = 0; f < NUM_PACKED_FEATURES; f++)
                for (int k = 0; k < NUM_PACKED_FILTERS; k++)
                    s2_sum[f][k] <= tree_sum[f][k];
        end
    end

    // next accumulator: a first beat restarts from the beat sum, otherwise add; then clamp
    always_comb begin
        for (int f = 0; f < NUM_PACKED_FEATURES; f++)
            for (int k = 0; k < NUM_PACKED_FILTERS; k++) begin
                acc_wide[f][k] = EXT_W'(s2_sum[f][k]);
                if (!s2_first)
                    acc_wide[f][k] = acc_wide[f][k] + EXT_W'(acc[f][k]);
                ovf_next[f][k] = ~s2_first & sticky[f][k];
                if (acc_wide[f][k] > ACC_MAX) begin
                    acc_next[f][k] = ACC_MAX[ACCUM_WIDTH-1:0];
                    ovf_next[f][k] = 1'b1;
                end else if (acc_wide[f][k] < ACC_MIN) begin
                    acc_next[f][k] = ACC_MIN[ACCUM_WIDTH-1:0];
                    ovf_next[f][k] = 1'b1;
                end else begin
                    acc_next[f][k] = acc_wide[f][k][ACCUM_WIDTH-1:0];
                end
            end
    end

    // S3: commit valid beats; a last beat publishes the window and pulses o_valid
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.o_valid    <= 1'b0;
            bus.o_result   <= '0;
            bus.o_overflow <= '0;
            for (int f = 0; f < NUM_PACKED_FEATURES; f++)
                for (int k = 0; k < NUM_PACKED_FILTERS; k++) begin
                    acc[f][k]    <= '0;
                    sticky[f][k] <= 1'b0;
                end
        end else begin
            bus.o_valid <= s2_valid & s2_last;
            if (s2_valid) begin
                for (int f = 0; f < NUM_PACKED_FEATURES; f++)
                    for (int k = 0; k < NUM_PACKED_FILTERS; k++) begin
                        acc[f][k]    <= acc_next[f][k];
                        sticky[f][k] <= ovf_next[f][k];
                        if (s2_last) begin
                            bus.o_result[f][k]   <= acc_next[f][k];
                            bus.o_overflow[f][k] <= ovf_next[f][k];
                        end
                    end
            end
        end
    end
endmodule

// File: tb/tb_pe_dot_accum_4xpack.sv
// tb/tb_pe_dot_accum_4xpack.sv - random and directed checks of pe_dot_accum_4xpack against a window model
module tb_pe_dot_accum_4xpack;
    localparam int D  = 8;
    localparam int MW = 9;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pe_dot_accum_4xpack_if #(.DOT_SIZE(D), .MULT_OUTPUT_WIDTH(MW), .ACCUM_WIDTH(24)) bus_a ();
    pe_dot_accum_4xpack_if #(.DOT_SIZE(D), .MULT_OUTPUT_WIDTH(MW), .ACCUM_WIDTH(12)) bus_b ();

    pe_dot_accum_4xpack #(.DOT_SIZE(D), .MULT_OUTPUT_WIDTH(MW), .ACCUM_WIDTH(24)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );
    pe_dot_accum_4xpack #(.DOT_SIZE(D), .MULT_OUTPUT_WIDTH(MW), .ACCUM_WIDTH(12)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        int              commit;
        bit              first;
        bit              last;
        logic [3:0][31:0] sum;
    } beat_t;

    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;
    beat_t   pend [$];
    logic [1:0][1:0][D-1:0][MW-1:0] mult;

    // model state per DUT (0: 24-bit, 1: 12-bit), lane index = feature*2+filter
    longint  acc_m [2][4];
    bit      stk_m [2][4];
    longint  rep_m [2][4];
    bit      rov_m [2][4];
    bit      exp_valid;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic longint smv(input logic [MW-1:0] p);
        longint m;
        m = longint'(p[MW-2:0]);
        return p[MW-1] ? -m : m;
    endfunction

    task automatic set_lane(input int f, input int k, input int val);
        logic [MW-1:0] e;
        e = {(val < 0), (MW-1)'((val < 0) ? -val : val)};
        for (int d = 0; d < D; d++) mult[f][k][d] = e;
    endtask

    // commit any beat whose window update lands at this cycle
    task automatic model_step();
        longint t, mx, mn;
        bit c;
        exp_valid = 1'b0;
        while (pend.size() > 0 && pend[0].commit <= cyc) begin
            beat_t b;
            b = pend.pop_front();
            for (int w = 0; w < 2; w++) begin
                mx = (longint'(1) << ((w == 0) ? 23 : 11)) - 1;
                mn = -mx - 1;
                for (int l = 0; l < 4; l++) begin
                    t = longint'($signed(b.sum[l]));
                    if (!b.first) t = t + acc_m[w][l];
                    c = 1'b0;
                    if (t > mx) begin t = mx; c = 1'b1; end
                    if (t < mn) begin t = mn; c = 1'b1; end
                    acc_m[w][l] = t;
                    stk_m[w][l] = (b.first ? 1'b0 : stk_m[w][l]) | c;
                    if (b.last) begin
                        rep_m[w][l] = acc_m[w][l];
                        rov_m[w][l] = stk_m[w][l];
                    end
                end
            end
            if (b.last) exp_valid = 1'b1;
        end
    endtask

    task automatic check_outputs();
        longint gr [2][4];
        bit     go [2][4];
        bit     gv [2];
        gv[0] = bus_a.o_valid;
        gv[1] = bus_b.o_valid;
        for (int l = 0; l < 4; l++) begin
            gr[0][l] = longint'($signed(bus_a.o_result[l/2][l%2]));
            gr[1][l] = longint'($signed(bus_b.o_result[l/2][l%2]));
            go[0][l] = bus_a.o_overflow[l/2][l%2];
            go[1][l] = bus_b.o_overflow[l/2][l%2];
        end
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("valid_w%0d", w), longint'(gv[w]), longint'(exp_valid));
            for (int l = 0; l < 4; l++) begin
                chk($sformatf("result_w%0d_l%0d", w, l), gr[w][l], rep_m[w][l]);
                chk($sformatf("ovf_w%0d_l%0d", w, l), longint'(go[w][l]), longint'(rov_m[w][l]));
            end
        end
    endtask

    task automatic drive(input bit v, input bit f, input bit l);
        beat_t b;
        bus_a.i_valid = v; bus_a.i_first = f; bus_a.i_last = l; bus_a.i_mult = mult;
        bus_b.i_valid = v; bus_b.i_first = f; bus_b.i_last = l; bus_b.i_mult = mult;
        if (v) begin
            b.commit = cyc + 3;
            b.first  = f;
            b.last   = l;
            for (int ln = 0; ln < 4; ln++) begin
                longint s;
                s = 0;
                for (int d = 0; d < D; d++) s = s + smv(mult[ln/2][ln%2][d]);
                b.sum[ln] = 32'(s);
            end
            pend.push_back(b);
        end
        @(posedge clock);
        cyc++;
        #1;
        model_step();
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_a.i_valid = 1'b0; bus_b.i_valid = 1'b0;
        @(posedge clock);
        cyc++;
        #1;
        reset = 1'b0;
        pend.delete();
        for (int w = 0; w < 2; w++)
            for (int l = 0; l < 4; l++) begin
                acc_m[w][l] = 0; stk_m[w][l] = 0; rep_m[w][l] = 0; rov_m[w][l] = 0;
            end
        exp_valid = 1'b0;
        check_outputs();
    endtask

    initial begin
        mult = '0;
        bus_a.i_valid = 1'b0; bus_a.i_first = 1'b0; bus_a.i_last = 1'b0; bus_a.i_mult = '0;
        bus_b.i_valid = 1'b0; bus_b.i_first = 1'b0; bus_b.i_last = 1'b0; bus_b.i_mult = '0;
        do_reset();
        do_reset();

        // single beat, two active lanes
        mult = '0; set_lane(0, 0, 3); set_lane(1, 1, -5);
        drive(1, 1, 1);
        mult = '0;
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("t1_valid", longint'(bus_a.o_valid), 1);
        chk("t1_r00", longint'($signed(bus_a.o_result[0][0])), 24);
        chk("t1_r11", longint'($signed(bus_a.o_result[1][1])), -40);
        chk("t1_r01", longint'($signed(bus_a.o_result[0][1])), 0);
        chk("t1_ovf", longint'(bus_a.o_overflow), 0);
        idle(2);

        // three beats with a bubble
        mult = '0; set_lane(0, 1, 255);  drive(1, 1, 0);
        mult = '0; set_lane(0, 1, -255); drive(1, 0, 0);
        drive(0, 0, 0);
        mult = '0; set_lane(0, 1, 1);    drive(1, 0, 1);
        mult = '0; idle(4);
        chk("t2_r01", longint'($signed(bus_a.o_result[0][1])), 8);

        // negative zero
        for (int f = 0; f < 2; f++) for (int k = 0; k < 2; k++) for (int d = 0; d < D; d++)
            mult[f][k][d] = 9'h100;
        drive(1, 1, 1);
        mult = '0; idle(4);
        chk("t3_r00", longint'($signed(bus_a.o_result[0][0])), 0);
        chk("t3_r11", longint'($signed(bus_a.o_result[1][1])), 0);

        // saturation on the 12-bit instance
        mult = '0; set_lane(1, 0, 255);
        drive(1, 1, 0);
        drive(1, 0, 1);
        mult = '0; idle(4);
        chk("t4_sat_r10", longint'($signed(bus_b.o_result[1][0])), 2047);
        chk("t4_sat_ovf10", longint'(bus_b.o_overflow[1][0]), 1);
        chk("t4_wide_r10", longint'($signed(bus_a.o_result[1][0])), 4080);
        mult = '0; set_lane(1, 0, 1);
        drive(1, 1, 1);
        mult = '0; idle(4);
        chk("t4_next_r10", longint'($signed(bus_b.o_result[1][0])), 8);
        chk("t4_next_ovf10", longint'(bus_b.o_overflow[1][0]), 0);

        // dropped window
        mult = '0; set_lane(0, 0, 1); drive(1, 1, 0);
        mult = '0; set_lane(0, 0, 2); drive(1, 1, 1);
        mult = '0; idle(4);
        chk("t5_drop_r00", longint'($signed(bus_a.o_result[0][0])), 16);

        // reset inside a window
        mult = '0; set_lane(0, 0, 1); drive(1, 1, 0);
        do_reset();
        chk("t5_rst_r00", longint'($signed(bus_a.o_result[0][0])), 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("t5_rst_novalid", longint'(bus_a.o_valid), 0);
        mult = '0; set_lane(0, 0, 1); drive(1, 0, 1);
        mult = '0; idle(4);

        // back-to-back single-beat windows
        mult = '0; set_lane(0, 0, 1);  drive(1, 1, 1);
        mult = '0; set_lane(0, 0, -1); drive(1, 1, 1);
        mult = '0;
        drive(0, 0, 0);
        chk("t6_v1", longint'(bus_a.o_valid), 1);
        chk("t6_r1", longint'($signed(bus_a.o_result[0][0])), 8);
        drive(0, 0, 0);
        chk("t6_v2", longint'(bus_a.o_valid), 1);
        chk("t6_r2", longint'($signed(bus_a.o_result[0][0])), -8);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int f = 0; f < 2; f++) for (int k = 0; k < 2; k++) for (int d = 0; d < D; d++)
                mult[f][k][d] = MW'($urandom_range(0, 511));
            if ($urandom_range(0, 99) == 0)
                do_reset();
            else
                drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0));
        end
        mult = '0;
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
